// File: rtl/led_demux_scan.sv
// led_demux_scan: registered 1-to-N LED demultiplexer with a manual select
// or a prescaled up / down / ping-pong scan.
// Optional blink gating is compiled in with `define LED_DEMUX_BLINK_EN.
module led_demux_scan #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data,
  input  logic [SEL_W-1:0]      select,
  input  logic [1:0]            mode,
  input  logic [DIV_W-1:0]      period,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  step
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] SEL_MAX  = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] SEL_ZERO = '0;
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  localparam logic [1:0] M_MANUAL = 2'b00;
  localparam logic [1:0] M_UP     = 2'b01;
  localparam logic [1:0] M_DOWN   = 2'b10;
  localparam logic [1:0] M_PING   = 2'b11;

  logic [DIV_W-1:0] cnt, cnt_eff, cnt_d;
  logic [1:0]       mode_q;
  logic             dir_down, dir_eff, dir_d;
  logic             mode_chg, tick, adv, data_eff;
  logic [SEL_W-1:0] sel_d;
  logic             step_d;
  logic [N-1:0]     out_d;
  logic             phase, phase_d;

`ifdef LED_DEMUX_BLINK_EN
  // Phase toggles per tick; the scan only advances on the lit->dark edge.
  always_comb begin
    phase_d  = tick ? ~phase : phase;
    adv      = tick & phase;
    data_eff = data & phase_d;
  end
`else
  // Without blink every tick advances and data passes straight through.
  always_comb begin
    phase_d  = 1'b0;
    adv      = tick;
    data_eff = data;
  end
`endif

  // Prescaler and select next-state. A mode change behaves as if the
  // counter were already 0 and the direction up in that same cycle, so the
  // new scan starts counting immediately from the kept cur_sel.
  always_comb begin
    mode_chg = (mode != mode_q);
    cnt_eff  = mode_chg ? '0 : cnt;
    dir_eff  = mode_chg ? 1'b0 : dir_down;
    tick     = (mode != M_MANUAL) && (cnt_eff == period);
    // Compare is live: a count already past a lowered period runs on to the
    // natural wrap of the counter without ticking.
    if (mode == M_MANUAL) cnt_d = '0;
    else if (tick)        cnt_d = '0;
    else                  cnt_d = cnt_eff + CNT_ONE;
    dir_d = dir_eff;
    sel_d = cur_sel;
    case (mode)
      M_MANUAL: sel_d = select;
      M_UP:     if (adv) sel_d = cur_sel + SEL_ONE;
      M_DOWN:   if (adv) sel_d = cur_sel - SEL_ONE;
      M_PING: begin
        if (adv) begin
          if (!dir_eff && cur_sel == SEL_MAX) begin
            dir_d = 1'b1;
            sel_d = SEL_MAX - SEL_ONE;
          end else if (dir_eff && cur_sel == SEL_ZERO) begin
            dir_d = 1'b0;
            sel_d = SEL_ONE;
          end else begin
            sel_d = dir_eff ? cur_sel - SEL_ONE : cur_sel + SEL_ONE;
          end
        end
      end
      default: sel_d = cur_sel;
    endcase
    step_d = adv && (sel_d != cur_sel);
  end

  // One-hot-or-zero decode of the next select.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < N; i++)
      out_d[i] = data_eff && (sel_d == SEL_W'(i));
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mode_q   <= M_MANUAL;
      dir_down <= 1'b0;
      phase    <= 1'b0;
      cur_sel  <= '0;
      out      <= '0;
      step     <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      mode_q   <= mode;
      dir_down <= dir_d;
      phase    <= phase_d;
      cur_sel  <= sel_d;
      out      <= out_d;
      step     <= step_d;
    end
  end

endmodule
